// File: rtl/vx_l1_mem_sched_pkg.sv
// Shared definitions for the L1 memory scheduler: arbiter mode codes,
// counter width, perf counter record and a saturating increment helper.
package vx_l1_mem_sched_pkg;

  // Arbiter mode codes (ASCII of the mode letter)
  localparam logic [7:0] ARB_PRIO = 8'h50;  // "P": fixed priority + anti-starvation
  localparam logic [7:0] ARB_RR   = 8'h52;  // "R": round-robin

  // Width of wait and pending counters; covers the 1..255 limits
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [31:0] grants;
    logic [31:0] stalls;
  } l1_sched_perf_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vx_l1_mem_sched_grant.sv
// Grant selection: turns the eligibility mask into a one-hot grant.
// "P" mode keeps per-input wait counters and promotes starved inputs;
// "R" mode keeps a rotating search pointer.
module vx_l1_mem_sched_grant
  import vx_l1_mem_sched_pkg::*;
#(
  parameter int         NUM_INPUTS = 2,
  parameter logic [7:0] ARBITER    = ARB_PRIO,
  parameter int         MAX_STARVE = 16,
  localparam int        LOG_N      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_INPUTS-1:0] valid_i,
  input  logic [NUM_INPUTS-1:0] eligible_i,
  input  logic [NUM_INPUTS-1:0] fire_i,
  output logic [NUM_INPUTS-1:0] grant_o
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(MAX_STARVE);
  localparam bit IS_RR = (ARBITER == ARB_RR);

  logic [CNT_W-1:0]      wait_q [NUM_INPUTS];
  logic [CNT_W-1:0]      wait_d [NUM_INPUTS];
  logic [LOG_N-1:0]      ptr_q, ptr_d;
  logic [NUM_INPUTS-1:0] starved, upper, pick;

  // Candidate set: RR prefers inputs at/after the pointer, P prefers starved ones
  always_comb begin
    starved = '0;
    upper   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      starved[k] = eligible_i[k] && (wait_q[k] == STARVE_LIM);
      upper[k]   = eligible_i[k] && (k >= int'(ptr_q));
    end
    if (IS_RR) pick = (|upper) ? upper : eligible_i;
    else       pick = (|starved) ? starved : eligible_i;
  end

  // Lowest-index member of the candidate set wins
  always_comb begin
    grant_o = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (pick[k]) begin
        grant_o    = '0;
        grant_o[k] = 1'b1;
      end
    end
  end

  // Next wait counters and RR pointer from this cycle's accepted request
  always_comb begin
    ptr_d = ptr_q;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (IS_RR || !valid_i[k] || fire_i[k]) wait_d[k] = '0;
      else                                   wait_d[k] = sat_inc(wait_q[k], STARVE_LIM);
      if (IS_RR && fire_i[k]) ptr_d = (k == NUM_INPUTS - 1) ? '0 : LOG_N'(k + 1);
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      for (int k = 0; k < NUM_INPUTS; k++) wait_q[k] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int k = 0; k < NUM_INPUTS; k++) wait_q[k] <= wait_d[k];
    end
  end

endmodule

// File: rtl/vx_l1_mem_sched.sv
// L1 memory scheduler: merges NUM_INPUTS requesters onto one request port
// through a 2-entry skid buffer, limits outstanding reads per input and
// demuxes responses by the index held in the tag LSBs.
// Optional feature macro VX_L1_SCHED_PERF_EN adds per-input grant/stall counters.
module vx_l1_mem_sched
  import vx_l1_mem_sched_pkg::*;
#(
  parameter int         NUM_INPUTS  = 2,
  parameter int         REQ_DATAW   = 600,
  parameter int         RSP_DATAW   = 512,
  parameter int         TAG_WIDTH   = 8,
  parameter logic [7:0] ARBITER     = ARB_PRIO,
  parameter int         MAX_STARVE  = 16,
  parameter int         MAX_PENDING = 4,
  localparam int        LOG_N       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int        OUT_TAGW    = TAG_WIDTH + LOG_N
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_INPUTS-1:0]           req_in_valid_i,
  input  logic [NUM_INPUTS*REQ_DATAW-1:0] req_in_data_i,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0] req_in_tag_i,
  output logic [NUM_INPUTS-1:0]           req_in_ready_o,
  output logic                            req_out_valid_o,
  output logic [REQ_DATAW-1:0]            req_out_data_o,
  output logic [OUT_TAGW-1:0]             req_out_tag_o,
  input  logic                            req_out_ready_i,
  input  logic                            rsp_in_valid_i,
  input  logic [RSP_DATAW-1:0]            rsp_in_data_i,
  input  logic [OUT_TAGW-1:0]             rsp_in_tag_i,
  output logic                            rsp_in_ready_o,
  output logic [NUM_INPUTS-1:0]           rsp_out_valid_o,
  output logic [NUM_INPUTS*RSP_DATAW-1:0] rsp_out_data_o,
  output logic [NUM_INPUTS*TAG_WIDTH-1:0] rsp_out_tag_o,
  input  logic [NUM_INPUTS-1:0]           rsp_out_ready_i,
  output logic                            busy_o,
  output logic                            tag_err_o
`ifdef VX_L1_SCHED_PERF_EN
  ,
  output logic [NUM_INPUTS*32-1:0]        perf_grants_o,
  output logic [NUM_INPUTS*32-1:0]        perf_stalls_o
`endif
);

  localparam logic [CNT_W-1:0] PEND_LIM = CNT_W'(MAX_PENDING);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NUM_INPUTS-1:0] is_write, eligible, grant, fire, rsp_fire;
  logic [CNT_W-1:0]      pend_q [NUM_INPUTS];
  logic [CNT_W-1:0]      pend_d [NUM_INPUTS];
  logic                  pend_any;
  logic                  space, push, pop;
  logic [REQ_DATAW-1:0]  push_data;
  logic [OUT_TAGW-1:0]   push_tag;
  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [REQ_DATAW-1:0]  buf_data_q [2];
  logic [OUT_TAGW-1:0]   buf_tag_q  [2];
  logic [LOG_N-1:0]      rsp_idx;
  logic                  rsp_bad;
  logic                  tag_err_q, tag_err_d;

  assign rsp_idx = rsp_in_tag_i[LOG_N-1:0];
  assign rsp_bad = ({1'b0, rsp_idx} >= (LOG_N + 1)'(NUM_INPUTS));

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
    assign is_write[gi] = req_in_data_i[gi*REQ_DATAW];
    assign eligible[gi] = req_in_valid_i[gi] && (is_write[gi] || (pend_q[gi] < PEND_LIM));
    assign rsp_out_valid_o[gi] = rsp_in_valid_i && (rsp_idx == LOG_N'(gi));
    assign rsp_out_data_o[gi*RSP_DATAW +: RSP_DATAW] = rsp_in_data_i;
    assign rsp_out_tag_o[gi*TAG_WIDTH +: TAG_WIDTH]  = rsp_in_tag_i[OUT_TAGW-1:LOG_N];
  end

  vx_l1_mem_sched_grant #(
    .NUM_INPUTS (NUM_INPUTS),
    .ARBITER    (ARBITER),
    .MAX_STARVE (MAX_STARVE)
  ) u_grant (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (req_in_valid_i),
    .eligible_i (eligible),
    .fire_i     (fire),
    .grant_o    (grant)
  );

  // Ready depends only on registered occupancy, never on req_out_ready_i
  assign space          = rst_ni && (count_q != 2'd2);
  assign req_in_ready_o = grant & {NUM_INPUTS{space}};
  assign fire           = req_in_ready_o & req_in_valid_i;
  assign push           = |fire;
  assign pop            = (count_q != 2'd0) && req_out_ready_i;
  assign rsp_fire       = rsp_out_valid_o & rsp_out_ready_i;

  // Select the accepted payload and append the source index to its tag
  always_comb begin
    push_data = '0;
    push_tag  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (fire[k]) begin
        push_data = req_in_data_i[k*REQ_DATAW +: REQ_DATAW];
        push_tag  = {req_in_tag_i[k*TAG_WIDTH +: TAG_WIDTH], LOG_N'(k)};
      end
    end
  end

  // Skid buffer occupancy and pointer update
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Outstanding-read bookkeeping; simultaneous accept and response cancel out
  always_comb begin
    pend_any = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      pend_d[k] = pend_q[k];
      if (fire[k] && !is_write[k] && !rsp_fire[k] && (pend_q[k] != CNT_MAX))
        pend_d[k] = pend_q[k] + CNT_W'(1);
      else if (rsp_fire[k] && !(fire[k] && !is_write[k]) && (pend_q[k] != '0))
        pend_d[k] = pend_q[k] - CNT_W'(1);
      pend_any = pend_any | (pend_q[k] != '0);
    end
  end

  // Bad-index responses are swallowed; otherwise backpressure comes from the target
  always_comb begin
    rsp_in_ready_o = rsp_bad;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (rsp_idx == LOG_N'(k)) rsp_in_ready_o = rsp_out_ready_i[k];
    end
  end

  assign tag_err_d = tag_err_q | (rsp_in_valid_i & rsp_bad);

  // Control state; reset empties the buffer and clears all counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      tag_err_q <= 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) pend_q[k] <= '0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tag_err_q <= tag_err_d;
      for (int k = 0; k < NUM_INPUTS; k++) pend_q[k] <= pend_d[k];
    end
  end

  // Buffer storage; validity is tracked by count_q so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= push_data;
      buf_tag_q[wr_ptr_q]  <= push_tag;
    end
  end

  assign req_out_valid_o = (count_q != 2'd0);
  assign req_out_data_o  = buf_data_q[rd_ptr_q];
  assign req_out_tag_o   = buf_tag_q[rd_ptr_q];
  assign busy_o          = pend_any || (count_q != 2'd0);
  assign tag_err_o       = tag_err_q;

`ifdef VX_L1_SCHED_PERF_EN
  l1_sched_perf_t perf_q [NUM_INPUTS];

  // Per-input grant and stall counters, free-running with wrap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_INPUTS; k++) perf_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        if (fire[k]) perf_q[k].grants <= perf_q[k].grants + 32'd1;
        if (req_in_valid_i[k] && !req_in_ready_o[k]) perf_q[k].stalls <= perf_q[k].stalls + 32'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_perf
    assign perf_grants_o[gi*32 +: 32] = perf_q[gi].grants;
    assign perf_stalls_o[gi*32 +: 32] = perf_q[gi].stalls;
  end
`endif

endmodule

// File: tb/tb_vx_l1_mem_sched.sv
// Directed bench for vx_l1_mem_sched: instance A (3 inputs, priority,
// MAX_PENDING=2) and instance B (4 inputs, round-robin).
module tb_vx_l1_mem_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic [2:0]  a_req_valid, a_req_ready;
  logic [47:0] a_req_data;
  logic [11:0] a_req_tag;
  logic        a_out_valid, a_out_ready;
  logic [15:0] a_out_data;
  logic [5:0]  a_out_tag;
  logic        a_rsp_valid, a_rsp_ready;
  logic [15:0] a_rsp_data;
  logic [5:0]  a_rsp_tag;
  logic [2:0]  a_rspo_valid, a_rspo_ready;
  logic [47:0] a_rspo_data;
  logic [11:0] a_rspo_tag;
  logic        a_busy, a_tag_err;

  // Instance B signals
  logic [3:0]  b_req_valid, b_req_ready;
  logic [63:0] b_req_data;
  logic [15:0] b_req_tag;
  logic        b_out_valid, b_out_ready;
  logic [15:0] b_out_data;
  logic [5:0]  b_out_tag;
  logic        b_rsp_valid, b_rsp_ready;
  logic [15:0] b_rsp_data;
  logic [5:0]  b_rsp_tag;
  logic [3:0]  b_rspo_valid, b_rspo_ready;
  logic [63:0] b_rspo_data;
  logic [15:0] b_rspo_tag;
  logic        b_busy, b_tag_err;

`ifdef VX_L1_SCHED_PERF_EN
  logic [95:0]  a_perf_g, a_perf_s;
  logic [127:0] b_perf_g, b_perf_s;
`endif

  vx_l1_mem_sched #(
    .NUM_INPUTS(3), .REQ_DATAW(16), .RSP_DATAW(16), .TAG_WIDTH(4),
    .ARBITER("P"), .MAX_STARVE(16), .MAX_PENDING(2)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_in_valid_i(a_req_valid), .req_in_data_i(a_req_data), .req_in_tag_i(a_req_tag),
    .req_in_ready_o(a_req_ready),
    .req_out_valid_o(a_out_valid), .req_out_data_o(a_out_data), .req_out_tag_o(a_out_tag),
    .req_out_ready_i(a_out_ready),
    .rsp_in_valid_i(a_rsp_valid), .rsp_in_data_i(a_rsp_data), .rsp_in_tag_i(a_rsp_tag),
    .rsp_in_ready_o(a_rsp_ready),
    .rsp_out_valid_o(a_rspo_valid), .rsp_out_data_o(a_rspo_data), .rsp_out_tag_o(a_rspo_tag),
    .rsp_out_ready_i(a_rspo_ready),
    .busy_o(a_busy), .tag_err_o(a_tag_err)
`ifdef VX_L1_SCHED_PERF_EN
    , .perf_grants_o(a_perf_g), .perf_stalls_o(a_perf_s)
`endif
  );

  vx_l1_mem_sched #(
    .NUM_INPUTS(4), .REQ_DATAW(16), .RSP_DATAW(16), .TAG_WIDTH(4),
    .ARBITER("R"), .MAX_STARVE(16), .MAX_PENDING(4)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_in_valid_i(b_req_valid), .req_in_data_i(b_req_data), .req_in_tag_i(b_req_tag),
    .req_in_ready_o(b_req_ready),
    .req_out_valid_o(b_out_valid), .req_out_data_o(b_out_data), .req_out_tag_o(b_out_tag),
    .req_out_ready_i(b_out_ready),
    .rsp_in_valid_i(b_rsp_valid), .rsp_in_data_i(b_rsp_data), .rsp_in_tag_i(b_rsp_tag),
    .rsp_in_ready_o(b_rsp_ready),
    .rsp_out_valid_o(b_rspo_valid), .rsp_out_data_o(b_rspo_data), .rsp_out_tag_o(b_rspo_tag),
    .rsp_out_ready_i(b_rspo_ready),
    .busy_o(b_busy), .tag_err_o(b_tag_err)
`ifdef VX_L1_SCHED_PERF_EN
    , .perf_grants_o(b_perf_g), .perf_stalls_o(b_perf_s)
`endif
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic       v;
    logic [5:0] tag;
    logic [2:0] ordy;
    logic [2:0] exp_ov;
    logic       exp_ir;
  } rsp_vec_t;

  typedef struct packed {
    logic [3:0] exp_ready;
    logic [5:0] exp_tag;
  } rr_vec_t;

  rsp_vec_t rv [5];
  rr_vec_t  rr [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int s;

    rv[0] = '{1'b1, {4'h5, 2'd0}, 3'b001, 3'b001, 1'b1};
    rv[1] = '{1'b1, {4'h6, 2'd1}, 3'b001, 3'b010, 1'b0};
    rv[2] = '{1'b1, {4'h9, 2'd2}, 3'b100, 3'b100, 1'b1};
    rv[3] = '{1'b0, {4'h1, 2'd2}, 3'b111, 3'b000, 1'b1};
    rv[4] = '{1'b1, {4'hA, 2'd3}, 3'b000, 3'b000, 1'b1};

    rr[0] = '{4'b0001, {4'h8, 2'd0}};
    rr[1] = '{4'b0010, {4'h9, 2'd1}};
    rr[2] = '{4'b0100, {4'hA, 2'd2}};
    rr[3] = '{4'b1000, {4'hB, 2'd3}};
    rr[4] = '{4'b0001, {4'h8, 2'd0}};

    a_req_valid = '0; a_req_data = '0; a_req_tag = '0; a_out_ready = 1'b0;
    a_rsp_valid = 1'b0; a_rsp_data = '0; a_rsp_tag = '0; a_rspo_ready = '0;
    b_req_valid = '0; b_req_data = '0; b_req_tag = '0; b_out_ready = 1'b0;
    b_rsp_valid = 1'b0; b_rsp_data = '0; b_rsp_tag = '0; b_rspo_ready = '0;

    // Reset state, with a write request already waiting on input 0
    a_req_valid = 3'b001;
    a_req_data[15:0] = 16'h0001;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", a_req_ready, 3'b000);
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_tag_err", a_tag_err, 1'b0);
    $display("reset: ready=%b out_valid=%b busy=%b", a_req_ready, a_out_valid, a_busy);
    a_req_valid = '0;
    rst_n = 1'b1;
    step();

    // Response routing table
    for (int i = 0; i < 5; i++) begin
      a_rsp_valid  = rv[i].v;
      a_rsp_tag    = rv[i].tag;
      a_rspo_ready = rv[i].ordy;
      a_rsp_data   = 16'h1230 + 16'(i);
      #1;
      chk("rsp_out_valid", a_rspo_valid, rv[i].exp_ov);
      chk("rsp_in_ready", a_rsp_ready, rv[i].exp_ir);
      chk("tag_err_before", a_tag_err, 1'b0);
      for (int j = 0; j < 3; j++) begin
        if (rv[i].exp_ov[j]) begin
          chk("rsp_out_tag", a_rspo_tag[j*4 +: 4], rv[i].tag[5:2]);
          chk("rsp_out_data", a_rspo_data[j*16 +: 16], 16'h1230 + 16'(i));
        end
      end
      $display("rsp vec %0d: tag=%h ordy=%b -> rsp_out_valid=%b rsp_in_ready=%b",
               i, rv[i].tag, rv[i].ordy, a_rspo_valid, a_rsp_ready);
      step();
    end
    a_rsp_valid = 1'b0;
    a_rspo_ready = '0;
    chk("tag_err_set", a_tag_err, 1'b1);
    repeat (3) step();
    chk("tag_err_sticky", a_tag_err, 1'b1);
    chk("rsp_busy_idle", a_busy, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("tag_err_cleared", a_tag_err, 1'b0);
    step();
    rst_n = 1'b1;
    $display("tag_err: cleared by reset");

    // Anti-starvation: inputs 0 and 1 write continuously
    a_out_ready = 1'b1;
    a_req_data  = {16'h0000, 16'h00B1, 16'h00A1};
    a_req_tag   = {4'h0, 4'hB, 4'hA};
    a_req_valid = 3'b011;
    for (int k = 0; k < 18; k++) begin
      #1;
      chk("starve_ready", a_req_ready, (k == 16) ? 3'b010 : 3'b001);
      if (k == 1) chk("starve_out_tag0", a_out_tag, {4'hA, 2'd0});
      if (k == 17) begin
        chk("starve_out_tag1", a_out_tag, {4'hB, 2'd1});
        chk("starve_out_data1", a_out_data, 16'h00B1);
      end
      $display("starve cycle %0d: ready=%b out_tag=%h", k, a_req_ready, a_out_tag);
      step();
    end
    a_req_valid = '0;
    step();
    step();
    chk("starve_drain_busy", a_busy, 1'b0);
    chk("starve_drain_valid", a_out_valid, 1'b0);

    // Backpressure: out_ready low for 5 cycles, input 2 streams writes
    a_out_ready = 1'b0;
    a_req_tag[11:8] = 4'h7;
    a_req_valid = 3'b100;
    acc = 0;
    s = 0;
    for (int k = 0; k < 5; k++) begin
      a_req_data[47:32] = 16'hC001 | 16'(s << 4);
      #1;
      if (a_req_ready[2]) begin
        acc++;
        s++;
      end
      $display("bp cycle %0d: ready=%b accepted=%0d", k, a_req_ready, acc);
      step();
    end
    chk("bp_accepted", acc, 2);
    a_req_valid = '0;
    a_out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_out_valid", a_out_valid, (j < 2) ? 1'b1 : 1'b0);
      if (j < 2) begin
        chk("bp_out_data", a_out_data, 16'hC001 | 16'(j << 4));
        chk("bp_out_tag", a_out_tag, {4'h7, 2'd2});
      end
      $display("bp drain %0d: valid=%b data=%h", j, a_out_valid, a_out_data);
      step();
    end

    // Pending limit: three reads on input 1, MAX_PENDING=2
    a_req_data[31:16] = 16'hD000;
    a_req_tag[7:4] = 4'h4;
    a_req_valid = 3'b010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("pend_ready", a_req_ready[1], (k < 2) ? 1'b1 : 1'b0);
      $display("pend cycle %0d: ready=%b", k, a_req_ready);
      step();
    end
    chk("pend_busy", a_busy, 1'b1);
    a_rsp_valid = 1'b1;
    a_rsp_tag = {4'h4, 2'd1};
    a_rspo_ready = 3'b010;
    #1;
    chk("pend_rsp_valid", a_rspo_valid, 3'b010);
    chk("pend_rsp_ready", a_rsp_ready, 1'b1);
    chk("pend_still_blocked", a_req_ready[1], 1'b0);
    step();
    a_rsp_valid = 1'b0;
    a_rspo_ready = '0;
    #1;
    chk("pend_third_accepted", a_req_ready[1], 1'b1);
    $display("pend: third read ready=%b after one response", a_req_ready[1]);
    step();
    a_req_valid = '0;
    step();
    step();

    // Reset with 2 buffered requests and 3 pending reads
    a_out_ready = 1'b0;
    a_req_data[15:0] = 16'hE000;
    a_req_valid = 3'b001;
    #1;
    chk("r_read0_ready", a_req_ready, 3'b001);
    step();
    a_req_data[15:0] = 16'hE001;
    #1;
    chk("r_write0_ready", a_req_ready, 3'b001);
    step();
    a_req_valid = '0;
    #1;
    chk("r_pre_out_valid", a_out_valid, 1'b1);
    chk("r_pre_busy", a_busy, 1'b1);
    rst_n = 1'b0;
    step();
    chk("r_out_valid", a_out_valid, 1'b0);
    chk("r_busy", a_busy, 1'b0);
    rst_n = 1'b1;
    step();
    chk("r_post_out_valid", a_out_valid, 1'b0);
    chk("r_post_busy", a_busy, 1'b0);
    $display("mid-transfer reset: out_valid=%b busy=%b", a_out_valid, a_busy);

    // Round-robin on instance B, all four inputs valid
    b_req_data  = {16'h0031, 16'h0021, 16'h0011, 16'h0001};
    b_req_tag   = {4'hB, 4'hA, 4'h9, 4'h8};
    b_out_ready = 1'b1;
    b_req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", b_req_ready, rr[k].exp_ready);
      step();
      chk("rr_out_tag", b_out_tag, rr[k].exp_tag);
      $display("rr cycle %0d: ready=%b out_tag=%h", k, b_req_ready, b_out_tag);
    end
    b_req_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/vx_l1_mem_sched.md
VX_L1_MEM_SCHED -- requirements
Module: VX_l1_mem_sched

Interface
REQ-001 Parameter NUM_INPUTS, default 2: number of L1 requesters (input 0 = icache, 1..N-1 = dcache ports).
REQ-002 Parameter REQ_DATAW, default 600: opaque request payload width (rw, addr, data, byteen, flags), rw at bit 0.
REQ-003 Parameter RSP_DATAW, default 512: response payload width.
REQ-004 Parameter TAG_WIDTH, default 8: input tag width; LOG_N = max(1, clog2(NUM_INPUTS)).
REQ-005 Parameter ARBITER, default "P": "P" fixed priority with anti-starvation, "R" round-robin.
REQ-006 Parameter MAX_STARVE, default 16: wait cycles before forced promotion; range 2..255.
REQ-007 Parameter MAX_PENDING, default 4: outstanding reads per input; range 1..255.
REQ-008 clk  input  1  clock, all state on rising edge.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 req_in_valid  input  NUM_INPUTS  per-input request valid.
REQ-011 req_in_data  input  NUM_INPUTS x REQ_DATAW  per-input payload.
REQ-012 req_in_tag  input  NUM_INPUTS x TAG_WIDTH  per-input tag.
REQ-013 req_in_ready  output  NUM_INPUTS  per-input accept.
REQ-014 req_out_valid / req_out_data / req_out_tag(TAG_WIDTH+LOG_N) / req_out_ready(in): merged request port.
REQ-015 rsp_in_valid / rsp_in_data(RSP_DATAW) / rsp_in_tag(TAG_WIDTH+LOG_N) / rsp_in_ready(out): merged response port.
REQ-016 rsp_out_valid / rsp_out_data / rsp_out_tag(TAG_WIDTH) per input; rsp_out_ready input NUM_INPUTS.
REQ-017 busy  output  1  any pending read or buffered request; tag_err  output  1  sticky bad-index flag.

Function
REQ-018 At most one input granted per cycle; handshake = req_in_valid & req_in_ready.
REQ-019 Input eligible iff valid, and (write, or pending count < MAX_PENDING).
REQ-020 req_in_ready[i] = 1 only for the granted eligible input while the output buffer has a free slot.
REQ-021 Output buffer: 2-entry skid FIFO; accepted request appears on req_out one cycle later; no combinational path req_out_ready -> req_in_ready.
REQ-022 req_out_tag = {req_in_tag, i}; index in LOG_N LSBs.
REQ-023 "P": lowest-index eligible wins, except inputs whose wait counter == MAX_STARVE win first (lowest index among those).
REQ-024 Wait counter i: +1 per cycle valid & not granted, saturating at MAX_STARVE; cleared on grant or valid low.
REQ-025 "R": search starts at pointer; on grant pointer = grant+1 mod NUM_INPUTS; wait counters unused.
REQ-026 Pending counter i: +1 on read accept, -1 on rsp_out handshake i; simultaneous -> unchanged; never wraps.
REQ-027 Response routing combinational, zero latency: idx = rsp_in_tag[LOG_N-1:0]; rsp_out_valid[idx] = rsp_in_valid; rsp_in_ready = rsp_out_ready[idx].
REQ-028 idx >= NUM_INPUTS: response consumed (rsp_in_ready=1), no rsp_out_valid, tag_err set until reset.
REQ-029 busy = any pending counter nonzero or buffer nonempty.

Reset
REQ-030 Reset low: FIFO empty, counters 0, RR pointer 0, tag_err 0, req_out_valid 0, req_in_ready 0, busy 0; release mid-transfer drops in-flight buffer content.

Configuration
REQ-031 VX_L1_SCHED_PERF_EN defined: add per-input 32-bit outputs perf_grants and perf_stalls (valid & !ready cycles), wrapping, reset to 0; undefined: ports and logic absent, behaviour otherwise identical.

Structure
REQ-032 VX_gpu_pkg holds ARB mode constants and l1_sched_perf_t; LOG_N computed locally.
REQ-033 One sub-module: VX_l1_sched_grant (eligibility mask + wait counters -> one-hot grant).

Verification
REQ-034 N=2 "P", both valid continuously, req_out_ready=1 -> input 1 granted on cycle 16 of wait, then input 0 resumes.
REQ-035 N=4 "R", all valid -> grants 0,1,2,3,0 on consecutive cycles; tags LSBs match.
REQ-036 MAX_PENDING=2, three reads on input 1, no responses -> third blocked; one response returns -> third accepted next cycle.
REQ-037 req_out_ready=0 for 5 cycles -> exactly 2 accepted, no loss/reorder on release.
REQ-038 N=3, rsp_in_tag LSBs=3 -> rsp_in_ready=1, no rsp_out_valid, tag_err=1 until reset.
REQ-039 reset asserted with 2 buffered, 3 pending -> next cycle req_out_valid=0, busy=0.
